// File: rtl/score_tracker_pkg.sv
// Shared parameters for the score tracker and its display driver: grade codes,
// FSM state encoding and the saturating counter helper.
package score_tracker_pkg;

    localparam int CNT_W = 8;

    localparam logic [3:0] GRADE_NONE = 4'd0;
    localparam logic [3:0] GRADE_C    = 4'd1;
    localparam logic [3:0] GRADE_B    = 4'd2;
    localparam logic [3:0] GRADE_A    = 4'd3;
    localparam logic [3:0] GRADE_S    = 4'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        GRADE = 2'd2
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/score_tracker_grade_calc.sv
// Combinational grading: compares the hit ratio against 7/8, 3/4 and 1/2
// using 11-bit products so no division is needed.
module grade_calc
    import score_tracker_pkg::*;
(
    input  logic [CNT_W-1:0] hits,
    input  logic [CNT_W-1:0] total,
    output logic [3:0]       grade
);

    logic [10:0] hits_x8, hits_x4, hits_x2;
    logic [10:0] total_x7, total_x3, total_x1;

    assign hits_x8  = {hits, 3'b000};
    assign hits_x4  = {1'b0, hits, 2'b00};
    assign hits_x2  = {2'b00, hits, 1'b0};
    assign total_x1 = {3'b000, total};
    assign total_x7 = total_x1 * 11'd7;
    assign total_x3 = total_x1 * 11'd3;

    // An empty song would satisfy every ratio test, so it is forced to C.
    always_comb begin
        grade = GRADE_C;
        if (total == '0)
            grade = GRADE_C;
        else if (hits_x8 >= total_x7)
            grade = GRADE_S;
        else if (hits_x4 >= total_x3)
            grade = GRADE_A;
        else if (hits_x2 >= total_x1)
            grade = GRADE_B;
    end

endmodule

// File: rtl/score_tracker.sv
// Rhythm-game score tracker: counts hit/total notes per song and grades it.
// Define SCORE_TRACKER_BEST_EN to keep a per-user best-grade table.
module score_tracker
    import score_tracker_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             note_valid,
    input  logic             note_hit,
    input  logic             song_end,
    input  logic             user,
    output logic [3:0]       score,
    output logic [3:0]       score_user,
    output logic [CNT_W-1:0] hits,
    output logic [CNT_W-1:0] total,
    output logic             busy,
    output logic             done
);

    state_e     state;
    logic [3:0] grade;

    grade_calc u_grade_calc (
        .hits  (hits),
        .total (total),
        .grade (grade)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            hits  <= '0;
            total <= '0;
            score <= GRADE_NONE;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= PLAY;
                        hits  <= '0;
                        total <= '0;
                    end
                end
                PLAY: begin
                    // A restart beats a coincident song_end.
                    if (start) begin
                        hits  <= '0;
                        total <= '0;
                    end else begin
                        if (note_valid) begin
                            total <= sat_inc(total);
                            if (note_hit)
                                hits <= sat_inc(hits);
                        end
                        if (song_end)
                            state <= GRADE;
                    end
                end
                GRADE: begin
                    score <= grade;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

`ifdef SCORE_TRACKER_BEST_EN
    logic [1:0][3:0] best;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            best <= '0;
        else if (state == GRADE && grade > best[user])
            best[user] <= grade;
    end

    assign score_user = best[user];
`else
    logic unused_user;
    assign unused_user = user;
    assign score_user  = score;
`endif

endmodule

// File: tb/tb_score_tracker.sv
// Randomized scoreboard bench for score_tracker; expected grades come from
// a ratio-based reference model, checked by a monitor whenever done pulses.
module tb_score_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, note_valid, note_hit, song_end, user;
    logic [3:0] score, score_user;
    logic [7:0] hits, total;
    logic       busy, done;

    score_tracker dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .note_valid (note_valid),
        .note_hit   (note_hit),
        .song_end   (song_end),
        .user       (user),
        .score      (score),
        .score_user (score_user),
        .hits       (hits),
        .total      (total),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sc;
        int su;
        int h;
        int t;
    } exp_s;

    exp_s sb[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   m_best[2];
    int   last_sc = 0;
    int   last_h  = 0;
    int   last_t  = 0;

    task automatic chk(input string nm, input int act, input int want);
        n_total++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, want);
        end
    endtask

    function automatic int ref_grade(input int h, input int t);
        real r;
        if (t == 0) return 1;
        r = real'(h) / real'(t);
        if (r >= 0.875) return 4;
        if (r >= 0.75)  return 3;
        if (r >= 0.5)   return 2;
        return 1;
    endfunction

    function automatic int exp_su(input int u);
`ifdef SCORE_TRACKER_BEST_EN
        return m_best[u];
`else
        return last_sc;
`endif
    endfunction

    task automatic push_song(input int n, input int k, input bit u);
        exp_s e;
        e.h  = (k > 255) ? 255 : k;
        e.t  = (n > 255) ? 255 : n;
        e.sc = ref_grade(e.h, e.t);
        if (e.sc > m_best[u]) m_best[u] = e.sc;
        last_sc = e.sc;
        last_h  = e.h;
        last_t  = e.t;
        e.su = exp_su(u);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_s e;
                e = sb.pop_front();
                chk("sb_score", int'(score), e.sc);
                chk("sb_score_user", int'(score_user), e.su);
                chk("sb_hits", int'(hits), e.h);
                chk("sb_total", int'(total), e.t);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait out GRADE and the done pulse, then confirm IDLE holds the results.
    task automatic finish_song(input string nm);
        chk({nm, "_grade_done"}, int'(done), 0);
        chk({nm, "_grade_busy"}, int'(busy), 1);
        step();
        chk({nm, "_done_lat"}, int'(done), 1);
        chk({nm, "_idle_busy"}, int'(busy), 0);
        step();
        chk({nm, "_done_pulse"}, int'(done), 0);
        note_valid = 1'b1;
        note_hit   = 1'b1;
        song_end   = 1'b1;
        step();
        note_valid = 1'b0;
        note_hit   = 1'b0;
        song_end   = 1'b0;
        step();
        chk({nm, "_hold_hits"}, int'(hits), last_h);
        chk({nm, "_hold_total"}, int'(total), last_t);
        chk({nm, "_hold_score"}, int'(score), last_sc);
        chk({nm, "_hold_busy"}, int'(busy), 0);
    endtask

    task automatic song(input string nm, input int n, input int k, input bit merge,
                        input bit u, input int gap_max);
        int gp;
        user  = u;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            gp = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (gp) begin
                note_hit = 1'($urandom);
                step();
            end
            note_valid = 1'b1;
            note_hit   = (i < k);
            if (merge && i == n - 1) song_end = 1'b1;
            step();
            note_valid = 1'b0;
            note_hit   = 1'b0;
            song_end   = 1'b0;
        end
        if (!merge || n == 0) begin
            song_end = 1'b1;
            step();
            song_end = 1'b0;
        end
        push_song(n, k, u);
        finish_song(nm);
    endtask

    initial begin
        int n, k;
        m_best[0] = 0;
        m_best[1] = 0;
        reset      = 1'b0;
        start      = 1'b0;
        note_valid = 1'b0;
        note_hit   = 1'b0;
        song_end   = 1'b0;
        user       = 1'b0;
        repeat (3) step();
        chk("rst_score", int'(score), 0);
        chk("rst_score_user", int'(score_user), 0);
        chk("rst_hits", int'(hits), 0);
        chk("rst_total", int'(total), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b1;
        step();

        // Notes and song_end are ignored while idle.
        note_valid = 1'b1;
        note_hit   = 1'b1;
        step();
        song_end = 1'b1;
        step();
        note_valid = 1'b0;
        note_hit   = 1'b0;
        song_end   = 1'b0;
        step();
        chk("idle_hits", int'(hits), 0);
        chk("idle_total", int'(total), 0);
        chk("idle_busy", int'(busy), 0);

        song("a_6of8", 8, 6, 1'b0, 1'b1, 0);
        song("b_4of8", 8, 4, 1'b0, 1'b1, 0);
        chk("best_u1", int'(score_user), exp_su(1));
        user = 1'b0;
        #1;
        chk("best_u0", int'(score_user), exp_su(0));
        song("c_3of8", 8, 3, 1'b0, 1'b1, 0);
        song("s_8of8", 8, 8, 1'b0, 1'b0, 0);
        song("empty", 0, 0, 1'b0, 1'b0, 0);
        song("sat300", 300, 300, 1'b0, 1'b1, 0);
        chk("sat_hits", int'(hits), 255);
        chk("sat_total", int'(total), 255);
        song("merge4", 4, 4, 1'b1, 1'b0, 0);

        // start wins over a coincident song_end: counters clear, no grade.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) begin
            note_valid = 1'b1;
            note_hit   = 1'b1;
            step();
        end
        note_valid = 1'b0;
        note_hit   = 1'b0;
        start      = 1'b1;
        song_end   = 1'b1;
        step();
        start    = 1'b0;
        song_end = 1'b0;
        chk("coin_busy", int'(busy), 1);
        chk("coin_hits", int'(hits), 0);
        chk("coin_total", int'(total), 0);
        step();
        step();
        chk("coin_no_done", int'(done), 0);
        chk("coin_still_play", int'(busy), 1);
        song_end = 1'b1;
        step();
        song_end = 1'b0;
        push_song(0, 0, user);
        finish_song("coin_end");

        for (int r = 0; r < 15; r++) begin
            n = int'($urandom_range(30, 0));
            k = int'($urandom_range(n, 0));
            song($sformatf("rnd%0d", r), n, k, 1'($urandom), 1'($urandom), 2);
        end

        // Asynchronous reset in the middle of a song.
        user  = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) begin
            note_valid = 1'b1;
            note_hit   = 1'b1;
            step();
        end
        note_valid = 1'b0;
        note_hit   = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_score", int'(score), 0);
        chk("mid_rst_score_user", int'(score_user), 0);
        chk("mid_rst_hits", int'(hits), 0);
        chk("mid_rst_total", int'(total), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        m_best[0] = 0;
        m_best[1] = 0;
        last_sc   = 0;
        step();
        reset = 1'b1;
        repeat (4) step();
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_done", int'(done), 0);

        song("post_rst", 8, 7, 1'b0, 1'b0, 1);
        user = 1'b1;
        #1;
        chk("post_rst_best_u1", int'(score_user), exp_su(1));

        repeat (3) step();
        chk("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/score_tracker.md
SCORE_TRACKER -- requirements
Module: score_tracker

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: start  in  1  one-cycle pulse, song playback begins.
REQ-004 SHALL have ports: note_valid  in  1  one-cycle pulse, one note window closed.
REQ-005 SHALL have ports: note_hit  in  1  qualifies note_valid, 1 = correct key pressed in that window.
REQ-006 SHALL have ports: song_end  in  1  one-cycle pulse, last note finished.
REQ-007 SHALL have ports: user  in  1  active user select (0 = user B, 1 = user A).
REQ-008 SHALL have ports: score  out  4  grade code of last completed song.
REQ-009 SHALL have ports: score_user  out  4  best grade recorded for the currently selected user.
REQ-010 SHALL have ports: hits  out  8  hit count of current or last song.
REQ-011 SHALL have ports: total  out  8  note count of current or last song.
REQ-012 SHALL have ports: busy  out  1  high in PLAY and GRADE.
REQ-013 SHALL have ports: done  out  1  one-cycle pulse when score updates.

Function
REQ-014 SHALL implement FSM states IDLE, PLAY, GRADE.
REQ-015 SHALL move IDLE->PLAY on start and clear hits/total in the same edge.
REQ-016 SHALL, in PLAY, increment total on note_valid and also increment hits when note_hit is 1.
REQ-017 SHALL saturate hits and total at 255; no wrap-around.
REQ-018 SHALL ignore note_hit when note_valid is 0, and ignore note_valid/song_end in IDLE.
REQ-019 SHALL move PLAY->GRADE on song_end; a note_valid in the same cycle is counted before grading.
REQ-020 SHALL restart on start in PLAY: clear counters, stay in PLAY, produce no grade.
REQ-021 SHALL, if start and song_end coincide in PLAY, treat start as winner (restart, no grade).
REQ-022 SHALL compute grade in GRADE with 11-bit unsigned arithmetic: S (4'd4) if hits*8 >= total*7; else A (4'd3) if hits*4 >= total*3; else B (4'd2) if hits*2 >= total; else C (4'd1).
REQ-023 SHALL grade total==0 as C.
REQ-024 SHALL, on the GRADE->IDLE edge, register score, pulse done for exactly one cycle, and return to IDLE (GRADE lasts one cycle; done appears 2 cycles after song_end).
REQ-025 SHALL hold hits, total and score stable in IDLE until the next start.
REQ-026 SHALL keep busy combinationally equal to (state != IDLE).

Reset
REQ-027 SHALL, on reset low, force state IDLE, score=0, score_user=0, hits=0, total=0, done=0, and clear the best table, regardless of clk.
REQ-028 SHALL abandon any song in progress on reset without producing done.

Configuration
REQ-029 SHALL support macro SCORE_TRACKER_BEST_EN.
REQ-030 SHALL, with SCORE_TRACKER_BEST_EN defined, keep a 2-entry best-grade table indexed by user, updated at done when the new grade exceeds the stored entry (user sampled at the GRADE cycle), with score_user = table[user] combinationally.
REQ-031 SHALL, without SCORE_TRACKER_BEST_EN, omit the table and drive score_user equal to score.

Structure
REQ-032 SHALL take grade codes GRADE_NONE=0, GRADE_C=1, GRADE_B=2, GRADE_A=3, GRADE_S=4 and the FSM state encoding from the shared parameter package used by the display driver.
REQ-033 SHALL place the grading comparator in one combinational sub-module grade_calc (in: hits, total; out: 4-bit grade).

Verification
REQ-034 SHALL cover: start, 8 note_valid all hit, song_end -> done 2 cycles later, score=4, hits=8, total=8.
REQ-035 SHALL cover: 8 notes with 6 hits -> score=3; then 8 notes with 4 hits -> score=2; then 8 notes with 3 hits -> score=1.
REQ-036 SHALL cover: start then song_end with no notes -> score=1; and 300 hit notes -> hits=255, total=255, score=4.
REQ-037 SHALL cover: note_valid+note_hit coincident with song_end on the 4th of 4 notes -> hits=4, total=4, score=4; and start coincident with song_end -> no done, counters 0, busy=1.
REQ-038 SHALL cover (BEST_EN): user=1 scores 3 then 2 -> score_user stays 3; switch user=0 -> score_user=0; reset low mid-PLAY -> all outputs 0, no done.
